// File: rtl/memory_module.sv
// Asymmetric simple-dual-port RAM: byte-wide write port A, word-wide (little-endian) read port B.
// Optional OUTPUT_REG_EN adds a second EN_B-gated output register (read latency 2 instead of 1).
module memory_module #(
  parameter int DIN_W    = 8,
  parameter int ADDR_A_W = 11,
  parameter int RATIO    = 4,
  parameter int DOUT_W   = 32,
  parameter int ADDR_B_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EN_A,
  input  logic                W_A,
  input  logic [ADDR_A_W-1:0] ADDR_A,
  input  logic [DIN_W-1:0]    DIN_A,
  input  logic                EN_B,
  input  logic [ADDR_B_W-1:0] ADDR_B,
  output logic [DOUT_W-1:0]   DOUT_B
);

  localparam int DEPTH = 2 ** ADDR_A_W;
  localparam int LSB_W = $clog2(RATIO);

  logic [DIN_W-1:0]  mem [0:DEPTH-1];
  logic [DOUT_W-1:0] rd_word;
  logic              wr_en;
  logic [DOUT_W-1:0] dout_d, dout_q;

  // Byte lane g of the word comes from byte address {ADDR_B, g}: lowest byte in the low lane.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign rd_word[g*DIN_W +: DIN_W] = mem[{ADDR_B, LSB_W'(g)}];
  end

  always_comb begin
    wr_en  = EN_A & W_A;
    dout_d = dout_q;
    if (EN_B) dout_d = rd_word;
  end

  // Memory shares the reset process only so that writes are blocked during reset;
  // its contents are never cleared. Read-first falls out of the non-blocking write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      if (wr_en) mem[ADDR_A] <= DIN_A;
      dout_q <= dout_d;
    end
  end

`ifdef OUTPUT_REG_EN
  logic [DOUT_W-1:0] dout2_d, dout2_q;

  always_comb begin
    dout2_d = dout2_q;
    if (EN_B) dout2_d = dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout2_q <= '0;
    else        dout2_q <= dout2_d;
  end

  assign DOUT_B = dout2_q;
`else
  assign DOUT_B = dout_q;
`endif

endmodule

// File: tb/tb_memory_module.sv
// Directed bench for memory_module: expected read words are queued when a read is issued
// and popped/compared when the registered output is sampled.
module tb_memory_module;

`ifdef OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        en_a, w_a, en_b;
  logic [10:0] addr_a;
  logic [7:0]  din_a;
  logic [8:0]  addr_b;
  logic [31:0] dout_b;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rnd_bytes [0:31];

  memory_module dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .EN_A   (en_a),
    .W_A    (w_a),
    .ADDR_A (addr_a),
    .DIN_A  (din_a),
    .EN_B   (en_b),
    .ADDR_B (addr_b),
    .DOUT_B (dout_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  task automatic check_out(input string tag);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but expected queue is empty", tag, dout_b);
    end else begin
      e = exp_q.pop_front();
      assert (dout_b === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, dout_b, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    check_out(tag);
  endtask

  // Drivers: inputs change just after a falling edge, outputs sampled at a falling edge
  task automatic idle();
    en_a = 1'b0; w_a = 1'b0; en_b = 1'b0;
  endtask

  task automatic write_byte(input logic [10:0] a, input logic [7:0] d);
    en_a = 1'b1; w_a = 1'b1; addr_a = a; din_a = d;
    @(negedge clk);
    en_a = 1'b0; w_a = 1'b0;
  endtask

  task automatic read_word(input logic [8:0] b, input logic [31:0] e, input string tag);
    en_b = 1'b1; addr_b = b;
    exp_q.push_back(e);
    repeat (LAT) @(negedge clk);
    en_b = 1'b0;
    check_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; addr_a = '0; din_a = '0; addr_b = '0;
    idle();
    repeat (2) @(negedge clk);
    check_now("reset_dout", 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential bytes, read back as packed words
    for (int i = 0; i < 16; i++) write_byte(11'(i), 8'(i));
    for (int b = 0; b < 4; b++)
      read_word(9'(b), {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, "seq_read");

    // Enable without write strobe must not write
    en_a = 1'b1; w_a = 1'b0; addr_a = 11'd0; din_a = 8'hFF;
    @(negedge clk);
    idle();
    read_word(9'd0, 32'h03020100, "no_write_strobe");

    // EN_B low holds the output while the address moves
    read_word(9'd1, 32'h07060504, "hold_read");
    addr_b = 9'd2;
    repeat (3) @(negedge clk);
    check_now("hold_en_b_low", 32'h07060504);

    // Same-edge write into the word being read returns the old byte
    en_a = 1'b1; w_a = 1'b1; addr_a = 11'd4; din_a = 8'hAA;
    en_b = 1'b1; addr_b = 9'd1;
    exp_q.push_back(32'h07060504);
    @(negedge clk);
    en_a = 1'b0; w_a = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    en_b = 1'b0;
    check_out("collision_old");
    read_word(9'd1, 32'h070605AA, "collision_new");

    // Asynchronous reset between edges; accesses during reset are ignored
    #2 rst_n = 1'b0;
    #1 check_now("async_reset_now", 32'h0);
    en_a = 1'b1; w_a = 1'b1; addr_a = 11'd12; din_a = 8'h55;
    en_b = 1'b1; addr_b = 9'd3;
    @(negedge clk);
    @(negedge clk);
    check_now("reset_blocks_read", 32'h0);
    idle();
    rst_n = 1'b1;
    read_word(9'd3, 32'h0F0E0D0C, "contents_kept");

    // Top of the address range
    write_byte(11'd2044, 8'h11);
    write_byte(11'd2045, 8'h22);
    write_byte(11'd2046, 8'h33);
    write_byte(11'd2047, 8'h44);
    read_word(9'd511, 32'h44332211, "top_word");

    // Random bytes into words 100..107
    for (int i = 0; i < 32; i++) begin
      rnd_bytes[i] = 8'($urandom_range(0, 255));
      write_byte(11'(400 + i), rnd_bytes[i]);
    end
    for (int w = 0; w < 8; w++)
      read_word(9'(100 + w), {rnd_bytes[4*w+3], rnd_bytes[4*w+2], rnd_bytes[4*w+1], rnd_bytes[4*w]},
                "random_word");

    // Report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
